// File: rtl/tex_scanout.sv
// Texture scan-out: fetches one image row per display line into a line buffer
// during horizontal blanking and streams it out as 4x-magnified grey pixels.
module tex_scanout #(
    parameter int IMG_WORDS = 28,
    parameter int IMG_ROWS  = 80,
    parameter int H_ACTIVE  = 640,
    parameter int V_TOTAL   = 525
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [11:0] rd_addr,
    input  logic [31:0] rd_data,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        busy,
    output logic        underrun
);

    localparam int KW = $clog2(IMG_WORDS + 1);
    localparam int IW = $clog2(IMG_WORDS);

    typedef enum logic [1:0] {IDLE, FETCH, LAST} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [11:0]   rd_addr_q, rd_addr_d;
    logic          busy_q, busy_d;
    logic          underrun_q, underrun_d;
    logic [7:0]    pix_q, pix_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic [31:0]   line_q [IMG_WORDS];
    logic [31:0]   line_d [IMG_WORDS];

    logic [9:0]    next_line;
    logic [9:0]    img_row;
    logic          trigger;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic          in_win;
    logic [IW-1:0] word_idx;
    logic [31:0]   sel_word;
    logic [1:0]    byte_sel;

    // The row fetched now is the one displayed on the following line.
    assign next_line = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    assign img_row   = next_line >> 2;
    assign trigger   = pix_en && (hcount == 10'(H_ACTIVE)) && (img_row < 10'(IMG_ROWS));

    // Synchronous memory: data for the address issued at k arrives one clk later.
    assign wr_en  = ((state_q == FETCH) && (k_q != '0)) || (state_q == LAST);
    assign wr_idx = IW'(k_q - KW'(1));

    assign in_win   = video_on && (hcount < 10'(IMG_WORDS * 16)) && (vcount < 10'(IMG_ROWS * 4));
    assign word_idx = IW'(hcount >> 4);
    assign byte_sel = hcount[3:2];

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        state_d    = state_q;
        k_d        = k_q;
        rd_addr_d  = rd_addr_q;
        line_d     = line_q;
        pix_d      = pix_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        sel_word   = '0;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d   = FETCH;
                    k_d       = '0;
                    rd_addr_d = 12'(img_row) * 12'(IMG_WORDS);
                end
            end
            FETCH: begin
                k_d = k_q + KW'(1);
                if (k_q == KW'(IMG_WORDS - 1)) begin
                    state_d = LAST;
                end else begin
                    rd_addr_d = rd_addr_q + 12'd1;
                end
            end
            LAST: begin
                state_d = IDLE;
                k_d     = '0;
            end
            default: state_d = IDLE;
        endcase

        if (wr_en) begin
            line_d[wr_idx] = rd_data;
        end

        busy_d     = (state_d != IDLE);
        underrun_d = underrun_q | (pix_en && (hcount == 10'd0) && video_on && busy_q);

        if (in_win) begin
            sel_word = line_q[word_idx];
        end
        if (pix_en) begin
            pix_d   = in_win ? sel_word[{byte_sel, 3'b000} +: 8] : 8'd0;
            hsync_d = hsync_in;
            vsync_d = vsync_in;
        end
    end

    // NOTE: the line buffer lives in flops rather than RAM so reset can clear every word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            pix_q      <= '0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            for (int i = 0; i < IMG_WORDS; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates so all flops sample pre-edge values together.
            state_q    <= state_d;
            k_q        <= k_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
            pix_q      <= pix_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            line_q     <= line_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign busy      = busy_q;
    assign underrun  = underrun_q;
    assign o_red     = pix_q;
    assign o_green   = pix_q;
    assign o_blue    = pix_q;
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;

endmodule

// File: tb/tb_tex_scanout.sv
// Directed bench for tex_scanout with a synchronous texture memory model
// (rd_data registers mem[rd_addr] on each rising edge).
module tb_tex_scanout;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [11:0] rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  o_red, o_green, o_blue;
    logic        hsync_out, vsync_out, busy, underrun;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [4096];

    tex_scanout dut (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .hcount    (hcount),
        .vcount    (vcount),
        .video_on  (video_on),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .o_red     (o_red),
        .o_green   (o_green),
        .o_blue    (o_blue),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .busy      (busy),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pe, input logic [9:0] h, input logic [9:0] v,
                         input logic von, input logic hs, input logic vs);
        @(negedge clk);
        pix_en   = pe;
        hcount   = h;
        vcount   = v;
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
    endtask

    // One pixel tick, then sample just after the edge that registered it.
    task automatic px(input logic [9:0] h, input logic [9:0] v, input logic von,
                      input logic hs, input logic vs);
        drive(1'b1, h, v, von, hs, vs);
        @(posedge clk);
        #1;
    endtask

    task automatic check_colour(input string tag, input logic [7:0] exp);
        check(tag, {8'h00, o_red, o_green, o_blue}, {8'h00, exp, exp, exp});
    endtask

    // Trigger held for several clks so a retrigger while busy would show up
    // as a restarted address sequence or a longer busy window.
    task automatic fetch(input logic [9:0] v, input int base, input string tag);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        drive(1'b1, 10'd640, v, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 80 && !done; i++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                if (n < 28) check({tag, "_addr"}, 32'(rd_addr), 32'(base + n));
                n++;
            end else begin
                done = (n > 0);
            end
            if (i == 4) pix_en = 1'b0;
        end
        pix_en = 1'b0;
        check({tag, "_busy_clks"}, 32'(n), 32'd29);
        check({tag, "_addr_hold"}, 32'(rd_addr), 32'(base + 27));
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = !busy;
        end
        check({tag, "_idle_timeout"}, 32'(ok), 32'd1);
    endtask

    initial begin
        bit any_busy;

        for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
        reset    = 1'b1;
        pix_en   = 1'b0;
        hcount   = '0;
        vcount   = '0;
        video_on = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(rd_addr), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check_colour("rst_colour", 8'h00);
        check("rst_syncs", {30'd0, hsync_out, vsync_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Line 3 fetches image row 1: words 28..55.
        fetch(10'd3, 28, "row1");
        px(10'd0,   10'd4, 1'b1, 1'b0, 1'b0); check_colour("row1_w0",  8'd28);
        px(10'd4,   10'd4, 1'b1, 1'b0, 1'b0); check_colour("row1_w0b1", 8'd0);
        px(10'd208, 10'd4, 1'b1, 1'b0, 1'b0); check_colour("row1_w13", 8'd41);
        px(10'd432, 10'd4, 1'b1, 1'b0, 1'b0); check_colour("row1_w27", 8'd55);

        // Byte order within a word, and sync alignment with colour.
        mem[28] = 32'h4433_2211;
        fetch(10'd3, 28, "row1b");
        for (int h = 0; h < 16; h++) begin
            px(10'(h), 10'd4, 1'b1, (h == 5), (h == 9));
            check_colour("bytes", 8'(8'h11 * (h / 4 + 1)));
            check("hs_align", 32'(hsync_out), 32'(h == 5));
            check("vs_align", 32'(vsync_out), 32'(h == 9));
        end
        drive(1'b0, 10'd0, 10'd4, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_colour("hold_no_tick", 8'h44);
        check("hold_hs", 32'(hsync_out), 32'd0);
        px(10'd0, 10'd4, 1'b1, 1'b1, 1'b1);
        check_colour("tick_colour", 8'h11);
        check("tick_syncs", {30'd0, hsync_out, vsync_out}, 32'd3);

        // Window edges and blanking.
        px(10'd448, 10'd4,   1'b1, 1'b0, 1'b0); check_colour("h_edge", 8'h00);
        px(10'd447, 10'd4,   1'b1, 1'b0, 1'b0); check_colour("h_in",   8'd0);
        px(10'd0,   10'd320, 1'b1, 1'b0, 1'b0); check_colour("v_edge", 8'h00);
        px(10'd0,   10'd319, 1'b1, 1'b0, 1'b0); check_colour("v_in",   8'h11);
        px(10'd0,   10'd4,   1'b0, 1'b0, 1'b0); check_colour("blank",  8'h00);

        // Last line of the frame prefetches row 0.
        fetch(10'd524, 0, "wrap");
        px(10'd16,  10'd0, 1'b1, 1'b0, 1'b0); check_colour("wrap_w1",  8'd1);
        px(10'd432, 10'd0, 1'b1, 1'b0, 1'b0); check_colour("wrap_w27", 8'd27);

        // Line 319 would prefetch row 80, which does not exist.
        drive(1'b1, 10'd640, 10'd319, 1'b0, 1'b0, 1'b0);
        any_busy = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            any_busy |= busy;
        end
        pix_en = 1'b0;
        check("nofetch_busy", 32'(any_busy), 32'd0);
        check("nofetch_addr", 32'(rd_addr), 32'd27);
        check("no_underrun_yet", 32'(underrun), 32'd0);

        // Reset in the middle of a fetch.
        drive(1'b1, 10'd640, 10'd3, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        pix_en = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("midfetch_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_addr", 32'(rd_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        px(10'd0,   10'd4, 1'b1, 1'b0, 1'b0); check_colour("midrst_w0",  8'h00);
        px(10'd432, 10'd4, 1'b1, 1'b0, 1'b0); check_colour("midrst_w27", 8'h00);
        check("midrst_still_idle", 32'(busy), 32'd0);
        fetch(10'd3, 28, "refetch");
        px(10'd0, 10'd4, 1'b1, 1'b0, 1'b0); check_colour("refetch_w0", 8'h11);

        // Visible line starts while the fetch is still running.
        check("pre_underrun", 32'(underrun), 32'd0);
        drive(1'b1, 10'd640, 10'd3, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        px(10'd0, 10'd4, 1'b1, 1'b0, 1'b0);
        check("underrun_set", 32'(underrun), 32'd1);
        pix_en = 1'b0;
        wait_idle("underrun");
        px(10'd0, 10'd4, 1'b1, 1'b0, 1'b0);
        px(10'd1, 10'd4, 1'b1, 1'b0, 1'b0);
        check("underrun_sticky", 32'(underrun), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("underrun_cleared", 32'(underrun), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
